// File: rtl/cnn_pkg.sv
// Shared constants, state encoding and helpers for the CNN MAC datapath.
package cnn_pkg;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 12;
   localparam int PROD_W = 2 * DATA_W;
   localparam int K_MAX  = 16;

   // Window sequencing of the MAC bank.
   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } mac_state_t;

   // Scaled lane term: upper byte of the unsigned 8x8 product, truncated.
   function automatic logic [DATA_W-1:0] scaled_term(input logic [DATA_W-1:0] d,
                                                      input logic [DATA_W-1:0] w);
      logic [PROD_W-1:0] p;
      p = PROD_W'(d) * PROD_W'(w);
      return p[PROD_W-1 -: DATA_W];
   endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: multiply, truncate to the upper byte, register the term,
// then add it into a 12-bit accumulator. clr empties both stages.
module mac_lane
   import cnn_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic [DATA_W-1:0] data,
   input  logic [DATA_W-1:0] weight,
   output logic [ACC_W-1:0]  acc
);

   logic [DATA_W-1:0] term_r;
   logic              p_valid;

   // Stage 1: capture the scaled term on an accepted beat; p_valid marks it for stage 2.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         term_r  <= '0;
         p_valid <= 1'b0;
      end else begin
         p_valid <= en;
         if (en) begin
            term_r <= scaled_term(data, weight);
         end
      end
   end

   // Stage 2: fold the registered term into the accumulator; K <= 16 keeps it below 4096.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc <= '0;
      end else if (p_valid) begin
         acc <= acc + ACC_W'(term_r);
      end
   end

endmodule

// File: rtl/mac_bank.sv
// Bank of N MAC lanes sharing one window FSM.
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready
// is only high in ACCUM, out_valid only in DONE, so they never overlap.
module mac_bank
   import cnn_pkg::*;
#(
   parameter int N = 9,
   parameter int K = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data     [0:N-1],
   input  logic [DATA_W-1:0] weight   [0:N-1],
   output logic [ACC_W-1:0]  mac_outs [0:N-1],
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(K - 1);

   if (K < 1 || K > K_MAX || N < 1) begin : g_bad_param
      $error("mac_bank: illegal parameters N=%0d K=%0d", N, K);
   end

   // state is kept as a named signal so checkers can bind to it directly.
   mac_state_t       state;
   mac_state_t       state_next;
   logic [CNT_W-1:0] beat_cnt;
   logic             accept;
   logic             last_beat;
   logic             clr;

   assign last_beat = (beat_cnt == LAST_BEAT);

   // Window state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACCUM;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake decode; in_ready is held low while rst is asserted.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      accept     = 1'b0;
      clr        = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = !rst;
            accept   = in_valid && !rst;
            if (accept && last_beat) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               clr        = 1'b1;
               state_next = ACCUM;
            end
         end
         default: begin
            state_next = ACCUM;
         end
      endcase
   end

   // Beat counter: advances only on accepted beats and wraps after beat K.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
      end else if (accept) begin
         if (last_beat) begin
            beat_cnt <= '0;
         end else begin
            beat_cnt <= beat_cnt + CNT_W'(1);
         end
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      mac_lane u_lane (
         .clk    (clk),
         .rst    (rst),
         .en     (accept),
         .clr    (clr),
         .data   (data[i]),
         .weight (weight[i]),
         .acc    (mac_outs[i])
      );
   end

endmodule

// File: tb/tb_mac_bank.sv
// Bench for mac_bank: three instances (N2/K4, N2/K16, N3/K1) share clock and reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_mac_bank;
   import cnn_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic             v4, rdy4, ov4, or4;
   logic [7:0]       d4 [0:1];
   logic [7:0]       w4 [0:1];
   logic [ACC_W-1:0] o4 [0:1];

   logic             v16, rdy16, ov16, or16;
   logic [7:0]       d16 [0:1];
   logic [7:0]       w16 [0:1];
   logic [ACC_W-1:0] o16 [0:1];

   logic             v1, rdy1, ov1, or1;
   logic [7:0]       d1 [0:2];
   logic [7:0]       w1 [0:2];
   logic [ACC_W-1:0] o1 [0:2];

   mac_bank #(.N(2), .K(4)) u_k4 (
      .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .data(d4), .weight(w4),
      .mac_outs(o4), .out_valid(ov4), .out_ready(or4));

   mac_bank #(.N(2), .K(16)) u_k16 (
      .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .data(d16), .weight(w16),
      .mac_outs(o16), .out_valid(ov16), .out_ready(or16));

   mac_bank #(.N(3), .K(1)) u_k1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .data(d1), .weight(w1),
      .mac_outs(o1), .out_valid(ov1), .out_ready(or1));

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [ACC_W-1:0] exp_q[$];

   function automatic logic [7:0] term_of(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'(a) * 16'(b);
      return p[15:8];
   endfunction

   // out_valid and in_ready must never be high together on any instance.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checks++;
         if ((ov4 === 1'b1 && rdy4 === 1'b1) || (ov16 === 1'b1 && rdy16 === 1'b1) ||
             (ov1 === 1'b1 && rdy1 === 1'b1)) begin
            failures++;
            $display("FAIL overlap: ov/rdy k4=%b%b k16=%b%b k1=%b%b expected never both 1",
                     ov4, rdy4, ov16, rdy16, ov1, rdy1);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive4(input logic [7:0] a0, input logic [7:0] b0,
                         input logic [7:0] a1, input logic [7:0] b1);
      v4 = 1'b1;
      d4[0] = a0; w4[0] = b0;
      d4[1] = a1; w4[1] = b1;
      @(negedge clk);
   endtask

   // Called right after the last accept: checks DRAIN, then DONE and the result.
   task automatic collect4(input string tag);
      logic [ACC_W-1:0] e;
      v4 = 1'b0;
      checks++;
      if (ov4 !== 1'b0 || rdy4 !== 1'b0) begin
         failures++;
         $display("FAIL %s_drain: out_valid=%b in_ready=%b expected 0 0", tag, ov4, rdy4);
      end
      @(negedge clk);
      checks++;
      if (ov4 !== 1'b1 || rdy4 !== 1'b0) begin
         failures++;
         $display("FAIL %s_done: out_valid=%b in_ready=%b expected 1 0", tag, ov4, rdy4);
      end
      for (int l = 0; l < 2; l++) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_queue: lane%0d no expected value queued", tag, l);
         end else begin
            e = exp_q.pop_front();
            if (o4[l] !== e) begin
               failures++;
               $display("FAIL %s_result lane%0d: got %h expected %h", tag, l, o4[l], e);
            end
         end
      end
   endtask

   // Handshake the result and check the bank is cleared and accepting again.
   task automatic release4(input string tag);
      or4 = 1'b1;
      @(negedge clk);
      or4 = 1'b0;
      checks++;
      if (ov4 !== 1'b0 || rdy4 !== 1'b1 || o4[0] !== '0 || o4[1] !== '0) begin
         failures++;
         $display("FAIL %s_clear: ov=%b rdy=%b outs=%h,%h expected 0 1 000,000",
                  tag, ov4, rdy4, o4[0], o4[1]);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      v4 = 0; or4 = 0; v16 = 0; or16 = 0; v1 = 0; or1 = 0;
      d4 = '{8'h00, 8'h00};  w4 = '{8'h00, 8'h00};
      d16 = '{8'h00, 8'h00}; w16 = '{8'h00, 8'h00};
      d1 = '{8'h00, 8'h00, 8'h00}; w1 = '{8'h00, 8'h00, 8'h00};
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rdy4 !== 1'b0 || rdy16 !== 1'b0 || rdy1 !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready: got %b%b%b expected 000", rdy4, rdy16, rdy1);
      end
      checks++;
      if (ov4 !== 1'b0 || ov16 !== 1'b0 || ov1 !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid: got %b%b%b expected 000", ov4, ov16, ov1);
      end
      for (int l = 0; l < 2; l++) begin
         checks++;
         if (o4[l] !== '0 || o16[l] !== '0) begin
            failures++;
            $display("FAIL reset_outs lane%0d: got %h,%h expected 000", l, o4[l], o16[l]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (rdy4 !== 1'b1 || rdy16 !== 1'b1 || rdy1 !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready: got %b%b%b expected 111", rdy4, rdy16, rdy1);
      end
   endtask

   task automatic test_k4_full();
      exp_q.push_back(12'h3F8);
      exp_q.push_back(12'h3F8);
      for (int b = 0; b < 4; b++) begin
         checks++;
         if (rdy4 !== 1'b1) begin
            failures++;
            $display("FAIL k4_full_ready beat%0d: got %b expected 1", b, rdy4);
         end
         drive4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      end
      collect4("k4_full");
      release4("k4_full");
   endtask

   task automatic test_gaps();
      int acc_beats;
      exp_q.push_back(12'h100);
      exp_q.push_back(12'h100);
      acc_beats = 0;
      for (int c = 0; c < 7; c++) begin
         if (c % 2 == 0) begin
            drive4(8'h80, 8'h80, 8'h80, 8'h80);
            acc_beats++;
         end else begin
            v4 = 1'b0;
            d4[0] = 8'hFF; w4[0] = 8'hFF; d4[1] = 8'hFF; w4[1] = 8'hFF;
            @(negedge clk);
         end
         checks++;
         if (u_k4.beat_cnt !== 2'(acc_beats % 4)) begin
            failures++;
            $display("FAIL gaps_beat_cnt cycle%0d: got %0d expected %0d",
                     c, u_k4.beat_cnt, acc_beats % 4);
         end
         if (c < 6) begin
            checks++;
            if (rdy4 !== 1'b1 || ov4 !== 1'b0) begin
               failures++;
               $display("FAIL gaps_state cycle%0d: rdy=%b ov=%b expected 1 0", c, rdy4, ov4);
            end
         end
      end
      collect4("gaps");
      release4("gaps");
   endtask

   task automatic test_hold();
      logic [ACC_W-1:0] s [0:1];
      logic [7:0] a0, b0, a1, b1;
      s = '{12'h000, 12'h000};
      for (int b = 0; b < 4; b++) begin
         a0 = 8'($urandom_range(0, 255)); b0 = 8'($urandom_range(0, 255));
         a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
         s[0] = s[0] + ACC_W'(term_of(a0, b0));
         s[1] = s[1] + ACC_W'(term_of(a1, b1));
         drive4(a0, b0, a1, b1);
      end
      exp_q.push_back(s[0]);
      exp_q.push_back(s[1]);
      collect4("hold");
      for (int c = 0; c < 5; c++) begin
         drive4(8'($urandom_range(0, 255)), 8'hFF, 8'($urandom_range(0, 255)), 8'hFF);
         checks++;
         if (ov4 !== 1'b1 || rdy4 !== 1'b0 || o4[0] !== s[0] || o4[1] !== s[1]) begin
            failures++;
            $display("FAIL hold cycle%0d: ov=%b rdy=%b outs=%h,%h expected 1 0 %h,%h",
                     c, ov4, rdy4, o4[0], o4[1], s[0], s[1]);
         end
      end
      v4 = 1'b0;
      release4("hold");
   endtask

   task automatic test_reset_mid();
      drive4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      drive4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      v4 = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (o4[0] !== '0 || o4[1] !== '0 || ov4 !== 1'b0 || rdy4 !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_during: outs=%h,%h ov=%b rdy=%b expected 000,000 0 0",
                  o4[0], o4[1], ov4, rdy4);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (o4[0] !== '0 || o4[1] !== '0 || rdy4 !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_after: outs=%h,%h rdy=%b expected 000,000 1",
                  o4[0], o4[1], rdy4);
      end
      exp_q.push_back(12'h3F8);
      exp_q.push_back(12'h3F8);
      for (int b = 0; b < 4; b++) drive4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      collect4("reset_mid");
      release4("reset_mid");
   endtask

   task automatic test_back_to_back();
      logic [ACC_W-1:0] s0, s1;
      logic [7:0] a0, b0, a1, b1;
      for (int win = 0; win < 2; win++) begin
         s0 = '0; s1 = '0;
         or4 = 1'b1;
         for (int b = 0; b < 4; b++) begin
            a0 = 8'($urandom_range(0, 255)); b0 = 8'($urandom_range(0, 255));
            a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
            s0 = s0 + ACC_W'(term_of(a0, b0));
            s1 = s1 + ACC_W'(term_of(a1, b1));
            drive4(a0, b0, a1, b1);
         end
         exp_q.push_back(s0);
         exp_q.push_back(s1);
         collect4("back_to_back");
         release4("back_to_back");
      end
   endtask

   task automatic test_k16();
      logic [ACC_W-1:0] e;
      exp_q.push_back(12'hFE0);
      exp_q.push_back(12'h010);
      for (int b = 0; b < 16; b++) begin
         v16 = 1'b1;
         d16 = '{8'hFF, 8'h10};
         w16 = '{8'hFF, 8'h10};
         @(negedge clk);
      end
      v16 = 1'b0;
      checks++;
      if (ov16 !== 1'b0 || rdy16 !== 1'b0) begin
         failures++;
         $display("FAIL k16_drain: ov=%b rdy=%b expected 0 0", ov16, rdy16);
      end
      @(negedge clk);
      checks++;
      if (ov16 !== 1'b1) begin
         failures++;
         $display("FAIL k16_done: ov=%b expected 1", ov16);
      end
      for (int l = 0; l < 2; l++) begin
         e = exp_q.pop_front();
         checks++;
         if (o16[l] !== e) begin
            failures++;
            $display("FAIL k16_result lane%0d: got %h expected %h", l, o16[l], e);
         end
      end
      or16 = 1'b1;
      @(negedge clk);
      or16 = 1'b0;
      checks++;
      if (ov16 !== 1'b0 || rdy16 !== 1'b1 || o16[0] !== '0 || o16[1] !== '0) begin
         failures++;
         $display("FAIL k16_clear: ov=%b rdy=%b outs=%h,%h expected 0 1 000,000",
                  ov16, rdy16, o16[0], o16[1]);
      end
   endtask

   task automatic test_k1();
      logic [ACC_W-1:0] e;
      exp_q.push_back(12'h000);
      exp_q.push_back(12'h001);
      exp_q.push_back(12'h001);
      checks++;
      if (rdy1 !== 1'b1) begin
         failures++;
         $display("FAIL k1_ready: got %b expected 1", rdy1);
      end
      v1 = 1'b1;
      d1 = '{8'h01, 8'h40, 8'hFF};
      w1 = '{8'hFF, 8'h04, 8'h02};
      @(negedge clk);
      v1 = 1'b0;
      checks++;
      if (ov1 !== 1'b0 || rdy1 !== 1'b0) begin
         failures++;
         $display("FAIL k1_drain: ov=%b rdy=%b expected 0 0", ov1, rdy1);
      end
      @(negedge clk);
      checks++;
      if (ov1 !== 1'b1) begin
         failures++;
         $display("FAIL k1_done: ov=%b expected 1", ov1);
      end
      for (int l = 0; l < 3; l++) begin
         e = exp_q.pop_front();
         checks++;
         if (o1[l] !== e) begin
            failures++;
            $display("FAIL k1_result lane%0d: got %h expected %h", l, o1[l], e);
         end
      end
      or1 = 1'b1;
      @(negedge clk);
      or1 = 1'b0;
      checks++;
      if (ov1 !== 1'b0 || rdy1 !== 1'b1 || o1[0] !== '0 || o1[1] !== '0 || o1[2] !== '0) begin
         failures++;
         $display("FAIL k1_clear: ov=%b rdy=%b outs=%h,%h,%h expected 0 1 zeros",
                  ov1, rdy1, o1[0], o1[1], o1[2]);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_k4_full();
      test_gaps();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      test_k16();
      test_k1();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
